// File: rtl/instruction_fetch.sv
// instruction_fetch: program-counter owner and instruction fetch stage.
// It requests one word at a time from instruction memory using a ready
// handshake. It holds the fetched word for decode and advances the PC,
// taking jumps and branches into account, when the core retires it.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic        retire,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] pc_plus4_d;
    logic [31:0] pc_d;

    // Sign-extended word offset of a conditional branch.
    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
        logic signed [31:0] off;
        off = {{14{imm[15]}}, imm, 2'b00};
        return off;
    endfunction

    // Branch target relative to the following instruction; wraps mod 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] imm);
        logic signed [31:0] off;
        off = branch_offset(imm);
        return base + $unsigned(off);
    endfunction

    // Pseudo-direct jump target: region bits come from pc+4.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

    // Sequential successor, computed from the registered PC only.
    always_comb begin
        pc_plus4_d = pc_q + 32'd4;
    end

    // Next PC selection for the held instruction; jump beats branch.
    always_comb begin
        pc_d = pc_plus4_d;
        if (Jump) begin
            pc_d = jump_target(pc_plus4_d[31:28], instr_q[25:0]);
        end else if (Branch && Zero) begin
            pc_d = branch_target(pc_plus4_d, instr_q[15:0]);
        end
    end

    // Fetch FSM: owns state, PC, held instruction, retire count and the
    // registered request/valid outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            count_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
                ST_FETCH: begin
                    // Wait states are unbounded; the request stays up.
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= ST_HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (retire) begin
                        pc_q    <= pc_d;
                        count_q <= count_q + 32'd1;
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_d;
    assign instr_count = count_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the single-cycle MIPS CPU: owns the program counter, issues word requests to instruction memory over a ready-based handshake, and holds the fetched instruction stable for the decode/control stage. It drives `opcode` (instr[31:26]) straight into the main control decoder. It consumes the resulting `Branch`/`Jump` decisions plus the ALU `Zero` flag to compute the next PC when the core retires the instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset. Bits [1:0] must be 0.
- `clk`  in  1  sole clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request, high only in FETCH
- `imem_addr`  out  32  byte address of requested word (= `pc`)
- `imem_ready`  in  1  memory response valid this cycle; qualifies `imem_rdata`
- `imem_rdata`  in  32  instruction word
- `instr_valid`  out  1  `instr` is valid and stable (HOLD state)
- `instr`  out  32  registered instruction
- `opcode`  out  6  `instr[31:26]`, to main control
- `pc`  out  32  address of current instruction
- `pc_plus4`  out  32  `pc + 4`, mod 2^32
- `Branch`  in  1  from main control
- `Jump`  in  1  from main control
- `Zero`  in  1  ALU equality flag
- `retire`  in  1  core has completed the held instruction; sampled only in HOLD
- `instr_count`  out  32  retired-instruction counter

## Operation
- Three-state FSM: IDLE, FETCH, HOLD.
- IDLE: entered on reset. Outputs quiet. Unconditionally moves to FETCH on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - When `imem_ready`=1 at an edge: capture `imem_rdata` into `instr` and go to HOLD.
  - Otherwise stay in FETCH. Wait states are unbounded.
- HOLD: `instr_valid`=1, `instr`/`pc` frozen.
  - When `retire`=1 at an edge: load `pc` with next_pc, increment `instr_count`, go to FETCH.
  - Otherwise stay in HOLD.
- next_pc, evaluated combinationally in HOLD from the held `instr`:
  - `Jump`=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - Else `Branch`=1 and `Zero`=1: pc_plus4 + (sign_extend(instr[15:0]) << 2), 32-bit mod 2^32.
  - Else: pc_plus4.
- All PC arithmetic is 32-bit and wraps silently. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `instr_count` is 32-bit and wraps from 32'hFFFF_FFFF to 0.
- Ignored inputs:
  - `imem_ready` outside FETCH has no effect.
  - `retire` outside HOLD has no effect.
  - `Branch`/`Jump`/`Zero` are don't-care unless `retire`=1 in HOLD.
- `Branch`=1 with `Jump`=1 simultaneously: the jump target is taken.

## Timing
- Reset (async, immediate on `rst` high):
  - state=IDLE, `pc`=RESET_PC, `instr`=0, `instr_count`=0
  - `imem_req`=0, `instr_valid`=0
  - `opcode`=0, `pc_plus4`=RESET_PC+4
- First edge after `rst` falls: IDLE→FETCH. `imem_req` rises in that cycle.
- Latency:
  - Edge where `imem_ready`=1 → `instr_valid`=1 in the following cycle.
  - Minimum 2 cycles per instruction (1 FETCH with zero-wait memory + 1 HOLD with immediate retire).
- `imem_req`, `imem_addr` and `instr_valid` are decoded from registered state/PC only. There are no combinational paths from inputs to them.
- `retire` edge: the new `pc` is visible in the next cycle with `imem_req`=1. `instr_valid` drops in that same cycle.
- `instr` holds its previous value through FETCH. Consumers must qualify it with `instr_valid`.
- Reset mid-FETCH or mid-HOLD:
  - Any pending memory response is dropped and the count is not incremented.
  - The fetch restarts at RESET_PC via IDLE.

## Test plan
- Reset and sequential fetch:
  - Setup: RESET_PC=0, zero-wait memory, `retire` held high, no branch/jump.
  - Required: `imem_addr` sequence 0,4,8,C on every second cycle; `instr_count`=4 after 4 retires; first `imem_req` one cycle after reset release.
- Wait states:
  - Stimulus: `imem_ready` low for 3 cycles at address 0x10.
  - Required: `imem_req`=1 and `imem_addr`=0x10 held throughout; `instr_valid` stays 0 until the cycle after ready.
- Taken beq, negative offset:
  - Stimulus: pc=0x40, instr=0x1000FFFE, Branch=1, Zero=1, retire.
  - Required: next `imem_addr`=0x3C.
  - Same instruction with Zero=0: next `imem_addr`=0x44.
- Jump:
  - Stimulus: pc=0x3000_0000, instr=0x0800_0100, Jump=1 and Branch=1.
  - Required: next `imem_addr`=0x3000_0400.
- Wrap and retire gating:
  - PC=32'hFFFF_FFFC, sequential retire → `imem_addr`=0.
  - `retire` pulsed during FETCH → no PC or count change.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously while in HOLD at pc=0x20 with `instr_count`=5.
  - Required: immediately `pc`=RESET_PC, `instr_valid`=0, `instr_count`=0; a stale `imem_ready` during reset is ignored.
